// File: rtl/dec_pkg.sv
// Shared definitions for the decryption arbiter, the serial receivers and the modexp core.
package dec_pkg;

    localparam int DEC_D_SIZE = 32;
    localparam int DEC_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        OUT
    } dec_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting channel strictly after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic              any,
    output logic [CH_W-1:0]   sel
);

    logic [CH_W:0] idx;

    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = '0;
        // Scan from the farthest candidate down so the nearest one is assigned last and wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = {1'b0, last_grant} + (CH_W + 1)'(k);
            if (idx >= (CH_W + 1)'(NUM_CH)) begin
                idx = idx - (CH_W + 1)'(NUM_CH);
            end
            if (req[idx[CH_W-1:0]]) begin
                any = 1'b1;
                sel = idx[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dec_arbiter.sv
// Shares one iterative decryption core among NUM_CH receivers in round-robin order.
// Optional core watchdog enabled by defining DEC_ARB_TIMEOUT_EN.
module dec_arbiter
    import dec_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int D_SIZE  = DEC_D_SIZE,
    parameter int TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             req,
    input  logic [NUM_CH*D_SIZE-1:0]      req_data,
    input  logic [NUM_CH*D_SIZE-1:0]      req_d,
    input  logic [NUM_CH*D_SIZE-1:0]      req_N,
    input  logic [NUM_CH*DEC_LEN_W-1:0]   req_n,
    output logic [NUM_CH-1:0]             ack,
    output logic                          core_start,
    output logic [D_SIZE-1:0]             core_data,
    output logic [D_SIZE-1:0]             core_d,
    output logic [D_SIZE-1:0]             core_N,
    input  logic                          core_done,
    input  logic [D_SIZE-1:0]             core_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_CH)-1:0]     out_ch,
    output logic [D_SIZE-1:0]             out_result,
    output logic [DEC_LEN_W-1:0]          out_n,
    output logic                          out_err
);

    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT < 1) begin : g_param_check
        $error("dec_arbiter: NUM_CH must be 2..8 and TIMEOUT at least 1");
    end

    logic [D_SIZE-1:0]    data_a [NUM_CH];
    logic [D_SIZE-1:0]    d_a    [NUM_CH];
    logic [D_SIZE-1:0]    mod_a  [NUM_CH];
    logic [DEC_LEN_W-1:0] len_a  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign data_a[g] = req_data[g*D_SIZE +: D_SIZE];
        assign d_a[g]    = req_d[g*D_SIZE +: D_SIZE];
        assign mod_a[g]  = req_N[g*D_SIZE +: D_SIZE];
        assign len_a[g]  = req_n[g*DEC_LEN_W +: DEC_LEN_W];
    end

    dec_state_t      state;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] ch;
    logic            any;
    logic [CH_W-1:0] sel;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .any        (any),
        .sel        (sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            ch         <= '0;
            ack        <= '0;
            core_start <= 1'b0;
            core_data  <= '0;
            core_d     <= '0;
            core_N     <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_result <= '0;
            out_n      <= '0;
            out_err    <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            ack        <= '0;
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        ch       <= sel;
                        ack[sel] <= 1'b1;
                        state    <= GRANT;
                    end
                end
                // ack is high this cycle; the requester may change its operands right after it.
                GRANT: begin
                    core_data <= data_a[ch];
                    core_d    <= d_a[ch];
                    core_N    <= mod_a[ch];
                    out_n     <= len_a[ch];
                    out_ch    <= ch;
                    if (mod_a[ch] == '0) begin
                        out_result <= '0;
                        out_err    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        core_start <= 1'b1;
                        state      <= START;
`ifdef DEC_ARB_TIMEOUT_EN
                        cnt        <= '0;
`endif
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef DEC_ARB_TIMEOUT_EN
                    cnt   <= cnt + 1'b1;
`endif
                end
                WAIT: begin
                    if (core_done) begin
                        out_result <= core_result;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
`ifdef DEC_ARB_TIMEOUT_EN
                    // cnt counts cycles since core_start, so this lands out_valid TIMEOUT cycles after it.
                    else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
                        out_result <= '0;
                        out_err    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        last_grant <= ch;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_arbiter.sv
// Scoreboard bench for dec_arbiter: directed timing cases plus randomized round-robin batches.
`timescale 1ns/1ps
module tb_dec_arbiter;

    localparam int NUM_CH = 4;
    localparam int D      = 32;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  n;
        logic        err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_CH-1:0]     req;
    logic [NUM_CH*D-1:0]   req_data;
    logic [NUM_CH*D-1:0]   req_d;
    logic [NUM_CH*D-1:0]   req_N;
    logic [NUM_CH*4-1:0]   req_n;
    logic [NUM_CH-1:0]     ack;
    logic                  core_start;
    logic [D-1:0]          core_data;
    logic [D-1:0]          core_d;
    logic [D-1:0]          core_N;
    logic                  core_done;
    logic [D-1:0]          core_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_ch;
    logic [D-1:0]          out_result;
    logic [3:0]            out_n;
    logic                  out_err;

    int   tests = 0;
    int   fails = 0;
    int   model_last = NUM_CH - 1;
    int   exp_ch[$];
    exp_t words[NUM_CH][$];
    int   ready_mode = 1;
    int   stub_lat = 4;
    bit   stub_rand = 1'b0;
    int   rearm_left = 0;

    always #5 clk = ~clk;

    dec_arbiter #(
        .NUM_CH  (NUM_CH),
        .D_SIZE  (D),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_d       (req_d),
        .req_N       (req_N),
        .req_n       (req_n),
        .ack         (ack),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_d      (core_d),
        .core_N      (core_N),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_result  (out_result),
        .out_n       (out_n),
        .out_err     (out_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        longint unsigned r, x;
        r = 64'd1 % m;
        x = 64'(b) % m;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r[31:0];
    endfunction

    // A requester presents a word; its eventual output is known right away.
    task automatic present(input int c, input logic [31:0] data, input logic [31:0] dexp,
                           input logic [31:0] nmod, input logic [3:0] n, input bit to_err);
        exp_t w;
        req_data[c*D +: D] = data;
        req_d[c*D +: D]    = dexp;
        req_N[c*D +: D]    = nmod;
        req_n[c*4 +: 4]    = n;
        w.n = n;
        if (nmod == 0 || to_err) begin
            w.res = '0;
            w.err = 1'b1;
        end else begin
            w.res = modexp(data, dexp, nmod);
            w.err = 1'b0;
        end
        words[c].push_back(w);
        req[c] = 1'b1;
    endtask

    // Every channel in mask stays pending until served: service order is a cyclic walk from last+1.
    function automatic void model_schedule(input logic [NUM_CH-1:0] mask);
        int base;
        base = model_last;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (base + k) % NUM_CH;
            if (mask[c]) begin
                exp_ch.push_back(c);
                model_last = c;
            end
        end
    endfunction

    task automatic measure(input int limit, output int ta, output int ts, output int tv,
                           output logic [NUM_CH-1:0] av);
        ta = -1; ts = -1; tv = -1; av = '0;
        for (int k = 0; k <= limit; k++) begin
            @(negedge clk);
            if (ack != 0 && ta < 0) begin
                ta = k;
                av = ack;
            end
            if (core_start && ts < 0) ts = k;
            if (out_valid) begin
                tv = k;
                break;
            end
            tick();
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((exp_ch.size() != 0 || req != 0) && k < limit) begin
            tick();
            k++;
        end
        chk("drain_in_time", 64'(k < limit), 64'd1);
        repeat (2) tick();
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {ack, core_start, core_data, core_d, core_N, out_valid, out_ch, out_result, out_n, out_err}, '0);
    endtask

    // Consumer
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stub core: fixed or random latency, computes data^d mod N
    initial begin
        int          lat;
        logic [31:0] r;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                lat = stub_rand ? int'($urandom_range(1, 8)) : stub_lat;
                r   = (core_N == 0) ? 32'd0 : modexp(core_data, core_d, core_N);
                repeat (lat) @(posedge clk);
                #1;
                core_done   = 1'b1;
                core_result = r;
                @(posedge clk);
                #1;
                core_done   = 1'b0;
                core_result = $urandom;
            end
        end
    end

    // Requesters: after ack either drop req and scramble operands, or present a fresh word
    initial begin
        logic [NUM_CH-1:0] g;
        forever begin
            @(negedge clk);
            if (ack != 0) begin
                g = ack;
                tick();
                for (int i = 0; i < NUM_CH; i++) begin
                    if (g[i]) begin
                        if (rearm_left > 0) begin
                            rearm_left--;
                            present(i, $urandom, $urandom, $urandom | 32'd1, 4'($urandom), 1'b0);
                        end else begin
                            req[i]           = 1'b0;
                            req_data[i*D +: D] = $urandom;
                            req_d[i*D +: D]    = $urandom;
                            req_N[i*D +: D]    = $urandom;
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        int   c;
        exp_t w;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_ch.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    c = exp_ch.pop_front();
                    chk("out_ch", 64'(out_ch), 64'(c));
                    if (words[c].size() == 0) begin
                        chk("word_available", 64'd0, 64'd1);
                    end else begin
                        w = words[c].pop_front();
                        chk("out_result", 64'(out_result), 64'(w.res));
                        chk("out_n", 64'(out_n), 64'(w.n));
                        chk("out_err", 64'(out_err), 64'(w.err));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                ta, ts, tv, cnt;
        logic [NUM_CH-1:0] av;
        logic [NUM_CH-1:0] mask;
        logic [39:0]       snap;
        int                c;

        reset = 1'b1; req = '0; req_data = '0; req_d = '0; req_N = '0; req_n = '0;
        repeat (3) tick();
        @(negedge clk);
        chk_zero_outputs("reset_outputs");
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single request, L=10
        stub_rand = 1'b0; stub_lat = 10; ready_mode = 1;
        present(0, 32'd5, 32'd3, 32'd33, 4'h9, 1'b0);
        model_schedule(4'b0001);
        measure(40, ta, ts, tv, av);
        chk("single_ack_cycle", 64'(ta), 64'd1);
        chk("single_ack_onehot", 64'(av), 64'b0001);
        chk("single_start_cycle", 64'(ts), 64'd2);
        chk("single_valid_cycle", 64'(tv), 64'd13);
        chk("single_result", 64'(out_result), 64'd26);
        chk("single_operands", {core_data, core_N}, {32'd5, 32'd33});
        chk("single_exponent", 64'(core_d), 64'd3);
        drain(200);

        // N==0 on channel 2
        present(2, 32'h1234, 32'd7, 32'd0, 4'h3, 1'b0);
        model_schedule(4'b0100);
        measure(20, ta, ts, tv, av);
        chk("n0_ack_cycle", 64'(ta), 64'd1);
        chk("n0_ack_onehot", 64'(av), 64'b0100);
        chk("n0_no_start", 64'(ts), -64'sd1);
        chk("n0_valid_cycle", 64'(tv), 64'd2);
        drain(200);

        // Backpressure with a second request pending
        ready_mode = 0; stub_lat = 3;
        present(1, $urandom, $urandom, $urandom | 32'd1, 4'h5, 1'b0);
        present(3, $urandom, $urandom, $urandom | 32'd1, 4'hA, 1'b0);
        model_schedule(4'b1010);
        measure(40, ta, ts, tv, av);
        chk("bp_ack_onehot", 64'(av), 64'b1000);
        chk("bp_valid_cycle", 64'(tv), 64'd6);
        snap = {out_valid, out_ch, out_result, out_n, out_err};
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            chk("bp_outputs_held", 64'({out_valid, out_ch, out_result, out_n, out_err}), 64'(snap));
            chk("bp_no_ack_or_start", 64'({ack, core_start}), 64'd0);
        end
        tick();
        ready_mode = 1;
        drain(300);

        // Contention: all four held and re-armed, two full rotations
        stub_rand = 1'b1;
        rearm_left = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) present(i, $urandom, $urandom, $urandom | 32'd1, 4'($urandom), 1'b0);
        model_schedule('1);
        model_schedule('1);
        drain(1000);

        // Randomized batches under random backpressure
        ready_mode = 2;
        for (int b = 0; b < 12; b++) begin
            mask = NUM_CH'($urandom_range(1, 15));
            for (int i = 0; i < NUM_CH; i++) begin
                if (mask[i]) begin
                    present(i, $urandom, $urandom,
                            ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, 4'($urandom), 1'b0);
                end
            end
            model_schedule(mask);
            drain(2000);
        end
        ready_mode = 1;

`ifdef DEC_ARB_TIMEOUT_EN
        // Core never answers in time; its late done must be ignored
        stub_rand = 1'b0; stub_lat = 30; ready_mode = 0;
        c = (model_last + 1) % NUM_CH;
        present(c, $urandom, $urandom, 32'd77, 4'h6, 1'b1);
        model_schedule(NUM_CH'(1 << c));
        measure(60, ta, ts, tv, av);
        chk("to_start_cycle", 64'(ts), 64'd2);
        chk("to_delay", 64'(tv - ts), 64'd16);
        repeat (20) tick();
        @(negedge clk);
        chk("to_late_done_ignored", 64'({out_valid, out_err, out_result}), {31'd0, 1'b1, 1'b1, 32'd0});
        tick();
        ready_mode = 1;
        drain(300);
`endif

        // Make channel 1 the last served, then abort a job on channel 3 with reset
        stub_rand = 1'b0; stub_lat = 4;
        present(1, $urandom, $urandom, $urandom | 32'd1, 4'h2, 1'b0);
        model_schedule(4'b0010);
        drain(200);
        stub_lat = 20;
        present(3, $urandom, $urandom, $urandom | 32'd1, 4'h4, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midop_reset_outputs");
        words[3].delete();
        model_last = NUM_CH - 1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("stale_done_no_output", 64'(cnt), 64'd0);
        tick();
        stub_lat = 4;
        present(0, $urandom, $urandom, $urandom | 32'd1, 4'h1, 1'b0);
        present(2, $urandom, $urandom, $urandom | 32'd1, 4'h8, 1'b0);
        model_schedule(4'b0101);
        measure(40, ta, ts, tv, av);
        chk("post_reset_grant", 64'(av), 64'b0001);
        drain(300);

        chk("scoreboard_empty", 64'(exp_ch.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
